// File: rtl/sram_port_arbiter_if.sv
// Bundle between the SRAM port arbiter, its requesters and the single-port SRAM.
// The arbiter takes the slave modport; the requester/SRAM side takes the master modport.
interface sram_port_arbiter_if #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        we;
   logic [NUM_REQ*ADDR_W-1:0] addr_in;
   logic [NUM_REQ*DATA_W-1:0] wdata_in;
   logic [DATA_W-1:0]         sram_rdata;
   logic [NUM_REQ-1:0]        gnt;
   logic                      sram_r_en;
   logic                      sram_w_en;
   logic [ADDR_W-1:0]         sram_addr;
   logic [DATA_W-1:0]         sram_wdata;
   logic [NUM_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]         rdata;

   modport slave (
      input  req, we, addr_in, wdata_in, sram_rdata,
      output gnt, sram_r_en, sram_w_en, sram_addr, sram_wdata, rvalid, rdata
   );

   modport master (
      output req, we, addr_in, wdata_in, sram_rdata,
      input  gnt, sram_r_en, sram_w_en, sram_addr, sram_wdata, rvalid, rdata
   );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter with burst lock sharing one single-port SRAM among NUM_REQ requesters.
// A grant lasts while req stays high, up to MAX_BURST accesses, followed by a one-cycle release.
module sram_port_arbiter #(
   parameter int unsigned NUM_REQ   = 3,
   parameter int unsigned ADDR_W    = 8,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_BURST = 16
) (
   input logic              clk,
   input logic              n_rst,
   sram_port_arbiter_if.slave bus
);
   localparam int unsigned IdxW = $clog2(NUM_REQ);
   localparam int unsigned CntW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_e;

   state_e              state_q, state_d;
   logic [NUM_REQ-1:0]  gnt_q, gnt_d;
   logic [NUM_REQ-1:0]  rvalid_q, rvalid_d;
   logic [IdxW-1:0]     gidx_q, gidx_d;
   logic [IdxW-1:0]     last_q, last_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   logic                access, r_en, w_en, pick_vld;
   logic [IdxW-1:0]     pick;
   logic [CntW-1:0]     cnt_inc;
   int unsigned         idx;

   // First requester found searching upward from last_q+1 with wrap-around.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = 0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         idx = (32'(last_q) + i) % NUM_REQ;
         if (!pick_vld && bus.req[IdxW'(idx)]) begin
            pick     = IdxW'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      access  = (state_q == StGrant) && bus.req[gidx_q];
      r_en    = access && !bus.we[gidx_q];
      w_en    = access && bus.we[gidx_q];
      cnt_inc = cnt_q + CntW'(access);

      unique case (state_q)
         StIdle: begin
            if (pick_vld) begin
               gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
               gidx_d  = pick;
               cnt_d   = '0;
               state_d = StGrant;
            end
         end
         StGrant: begin
            cnt_d = cnt_inc;
            // A dropped req and a full burst in the same cycle take the same single exit.
            if (!bus.req[gidx_q] || cnt_inc == CntW'(MAX_BURST)) begin
               gnt_d   = '0;
               last_d  = gidx_q;
               state_d = StRelease;
            end
         end
         StRelease: state_d = StIdle;
         default:   state_d = StIdle;
      endcase

      if (state_q == StGrant) begin
         addr_d  = bus.addr_in[gidx_q*ADDR_W +: ADDR_W];
         wdata_d = bus.wdata_in[gidx_q*DATA_W +: DATA_W];
      end else begin
         addr_d  = addr_q;
         wdata_d = wdata_q;
      end
      rvalid_d = r_en ? gnt_q : '0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= StIdle;
         gnt_q    <= '0;
         rvalid_q <= '0;
         gidx_q   <= '0;
         last_q   <= IdxW'(NUM_REQ - 1);
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         gidx_q   <= gidx_d;
         last_q   <= last_d;
         cnt_q    <= cnt_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign bus.gnt        = gnt_q;
   assign bus.sram_r_en  = r_en;
   assign bus.sram_w_en  = w_en;
   assign bus.sram_addr  = addr_d;
   assign bus.sram_wdata = wdata_d;
   assign bus.rvalid     = rvalid_q;
   assign bus.rdata      = bus.sram_rdata;
endmodule
